perceptron_sample_loader: RTL and testbench
===========================================

# perceptron_sample_loader

Upstream feeder for the perceptron training stage. It accepts training samples as a byte stream through a valid/ready input port and stores them in an on-chip sample buffer. It then replays the buffer to the trainer as one sample per handshake, repeating for a fixed number of epochs. This replaces the hard-coded sample/label constants currently baked into the trainer, so samples are supplied at run time.

## Interface

- N_SAMPLES, 3, number of training samples held in the buffer (≥1)
- DIM, 2, features per sample (≥1)
- DATA_W, 4, feature width in bits (≤8); only low DATA_W bits of each feature byte are kept
- EPOCHS, 4, number of full passes over the buffer per load (≥1)
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- restart  input  1  abort current activity and return to LOAD (level, sampled each cycle)
- in_valid  input  1  producer has a byte on in_data
- in_data  input  8  feature or label byte
- in_ready  output  1  loader accepts a byte this cycle
- out_valid  output  1  sample presented to trainer
- out_ready  input  1  trainer accepts sample
- out_x  output  DIM*DATA_W  features; feature d at bits [d*DATA_W +: DATA_W]
- out_y  output  1  label
- out_idx  output  clog2(N_SAMPLES) (min 1)  sample index within epoch
- out_last  output  1  high with last sample of final epoch
- epoch  output  clog2(EPOCHS+1) (min 1)  count of completed epochs
- done  output  1  all epochs streamed

## Operation

- States: LOAD, STREAM, DONE.
- LOAD: in_ready=1, out_valid=0. Bytes are accepted on in_valid&in_ready. Order per sample: DIM feature bytes (d=0 first), then 1 label byte. Only in_data[0] is kept for the label; other bits are ignored. Samples are loaded in index order 0..N_SAMPLES-1. Write pointers: sample s, field f (0..DIM, where DIM is the label).
- Acceptance of the final byte (s=N_SAMPLES-1, f=DIM) moves the block to STREAM on the next cycle. It also resets idx=0 and epoch=0.
- STREAM: in_ready=0, out_valid=1. out_x/out_y come from buffer[idx]. They are held stable while out_valid&!out_ready.
- On each transfer (out_valid&out_ready):
  - If idx<N_SAMPLES-1, idx increments.
  - Otherwise idx wraps to 0 and epoch increments.
  - When epoch reaches EPOCHS, the block moves to DONE.
- out_last = (idx==N_SAMPLES-1) && (epoch==EPOCHS-1), qualified by STREAM.
- DONE: done=1, out_valid=0, in_ready=0. The block holds until restart or reset. epoch reads EPOCHS.
- restart=1 in any state moves the block to LOAD on the next cycle and clears write pointers, idx, epoch and done. The buffer contents are retained but overwritten by the next load.
- restart has priority over a simultaneous input or output handshake. An in_data byte is not stored, and the loader does not advance idx. Producers and consumers must not assert valid/ready during restart.
- in_valid is ignored outside LOAD. out_ready is ignored outside STREAM.

## Timing

- Reset (rst_n=0 at an edge): state=LOAD, buffer cleared to 0, pointers/idx/epoch=0. Outputs after that edge: in_ready=1, out_valid=0, out_x=0, out_y=0, out_idx=0, out_last=0, epoch=0, done=0.
- Reset mid-load or mid-stream behaves identically: partial data is discarded and no output glitches beyond the next edge.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Load latency: the cycle after the last byte is accepted, out_valid=1 with sample 0.
- Throughput: 1 byte/cycle in LOAD, 1 sample/cycle in STREAM when out_ready is held high.
- Full stream with out_ready tied high lasts N_SAMPLES*EPOCHS cycles. done rises the cycle after the out_last transfer.

## Test plan

- Reset then load bytes 2,3,0, 4,5,1, 1,2,1 with in_valid high every cycle. Required: in_ready=1 for 9 cycles. Next cycle out_valid=1, out_x=8'h32, out_y=0, out_idx=0.
- Same data with out_ready=1 continuously. Required: 12 transfers cycling x=32,54,21 and y=0,1,1. epoch steps 0→4. out_last only on transfer 12. done=1 the following cycle, out_valid=0.
- Backpressure: toggle out_ready 1,0,0,1. Required: out_x/out_idx are unchanged across stalled cycles and no sample is skipped or duplicated.
- Upper-bit masking: feature byte 8'hF7 and label byte 8'hFE. Required: stored feature 4'h7, label 0.
- Assert restart on cycle 5 of streaming. Required: next cycle in_ready=1, out_valid=0, epoch=0. A new load of 9 bytes streams the new values.
- rst_n=0 after 4 loaded bytes, then a full 9-byte load. Required: stream begins with the new sample 0, and no stale bytes appear.

Source files
------------

// File: rtl/perceptron_sample_loader_if.sv
// Byte-stream load port and sample-stream replay port of the perceptron sample loader.
// slave is the loader side; master is the producer/trainer side.
interface perceptron_sample_loader_if #(
  parameter int DIM    = 2,
  parameter int DATA_W = 4,
  parameter int IDX_W  = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DIM*DATA_W-1:0]   out_x;
  logic                    out_y;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_x, out_y, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_idx, out_last
  );
endinterface

// File: rtl/perceptron_sample_loader.sv
// Loads N_SAMPLES training samples from a byte stream, then replays them to the
// perceptron trainer for EPOCHS passes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_LOAD   | accepting feature/label bytes into the sample buffer
// S_STREAM | presenting buffer[idx] to the trainer, one sample per transfer
// S_DONE   | all epochs streamed; idle until restart or reset
module perceptron_sample_loader #(
  parameter int N_SAMPLES = 3,
  parameter int DIM       = 2,
  parameter int DATA_W    = 4,
  parameter int EPOCHS    = 4,
  localparam int IDX_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int EP_W     = $clog2(EPOCHS + 1),
  localparam int F_W      = $clog2(DIM + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         restart,
  perceptron_sample_loader_if.slave    bus,
  output logic [EP_W-1:0]              epoch,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]     feat_q [N_SAMPLES][DIM];
  logic [N_SAMPLES-1:0]  label_q;
  logic [IDX_W-1:0]      wr_s_q;
  logic [F_W-1:0]        wr_f_q;
  logic [IDX_W-1:0]      idx_q;
  logic [EP_W-1:0]       epoch_q;

  logic                  in_ready_d;
  logic                  out_valid_d;
  logic                  done_d;
  logic [DIM*DATA_W-1:0] x_sel;
  logic                  y_sel;

  logic in_fire, out_fire, wr_label, load_last, idx_last, ep_last;

  // Upper bits of each byte are discarded by design.
  logic unused_in_bits;
  assign unused_in_bits = ^bus.in_data;

  assign in_fire   = (state_q == S_LOAD) && bus.in_valid;
  assign out_fire  = (state_q == S_STREAM) && bus.out_ready;
  assign wr_label  = (wr_f_q == F_W'(DIM));
  assign load_last = in_fire && wr_label && (wr_s_q == IDX_W'(N_SAMPLES - 1));
  assign idx_last  = (idx_q == IDX_W'(N_SAMPLES - 1));
  assign ep_last   = (epoch_q == EP_W'(EPOCHS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (load_last) state_d = S_STREAM;
      end
      S_STREAM: begin
        out_valid_d = 1'b1;
        if (out_fire && idx_last && ep_last) state_d = S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
    if (restart) state_d = S_LOAD;
  end

  // Buffer writes use an explicit per-entry decode so pointer values beyond the
  // buffer size can never alias onto a real entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < N_SAMPLES; s++) begin
        for (int d = 0; d < DIM; d++) begin
          feat_q[s][d] <= '0;
        end
      end
      label_q <= '0;
      wr_s_q  <= '0;
      wr_f_q  <= '0;
      idx_q   <= '0;
      epoch_q <= '0;
    end else if (restart) begin
      wr_s_q  <= '0;
      wr_f_q  <= '0;
      idx_q   <= '0;
      epoch_q <= '0;
    end else begin
      if (in_fire) begin
        for (int s = 0; s < N_SAMPLES; s++) begin
          if (wr_s_q == IDX_W'(s)) begin
            if (wr_label) begin
              label_q[s] <= bus.in_data[0];
            end
            for (int d = 0; d < DIM; d++) begin
              if (wr_f_q == F_W'(d)) feat_q[s][d] <= bus.in_data[DATA_W-1:0];
            end
          end
        end
        if (load_last) begin
          wr_s_q  <= '0;
          wr_f_q  <= '0;
          idx_q   <= '0;
          epoch_q <= '0;
        end else if (wr_label) begin
          wr_f_q <= '0;
          wr_s_q <= wr_s_q + IDX_W'(1);
        end else begin
          wr_f_q <= wr_f_q + F_W'(1);
        end
      end
      if (out_fire) begin
        if (idx_last) begin
          idx_q   <= '0;
          epoch_q <= epoch_q + EP_W'(1);
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    x_sel = '0;
    y_sel = 1'b0;
    for (int s = 0; s < N_SAMPLES; s++) begin
      if (idx_q == IDX_W'(s)) begin
        for (int d = 0; d < DIM; d++) begin
          x_sel[d*DATA_W +: DATA_W] = feat_q[s][d];
        end
        y_sel = label_q[s];
      end
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_d;
  assign bus.out_x     = x_sel;
  assign bus.out_y     = y_sel;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = (state_q == S_STREAM) && idx_last && ep_last;
  assign epoch         = epoch_q;
  assign done          = done_d;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Self-checking bench for perceptron_sample_loader: table of load vectors replayed
// under different out_ready patterns, plus restart and mid-load reset sequences.
module tb_perceptron_sample_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] epoch;
  logic       done;

  perceptron_sample_loader_if #(.DIM(2), .DATA_W(4), .IDX_W(2)) bus ();

  perceptron_sample_loader #(
    .N_SAMPLES(3), .DIM(2), .DATA_W(4), .EPOCHS(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bus     (bus.slave),
    .epoch   (epoch),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic       y;
    logic [1:0] idx;
    logic       last;
    logic [2:0] ep;
  } exp_t;

  // bytes: byte 0 in the top byte; xs: sample 0 in the top byte; ys: sample 0 in bit 2
  typedef struct packed {
    logic [71:0] bytes;
    logic [23:0] xs;
    logic [2:0]  ys;
    logic [1:0]  mode;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[3];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      e.x    = v.xs[23 - 8*(k % 3) -: 8];
      e.y    = v.ys[2 - (k % 3)];
      e.idx  = 2'(k % 3);
      e.last = (k == 11);
      e.ep   = 3'(k / 3);
      sb.push_back(e);
    end
  endtask

  task automatic load(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("in_ready_load", bus.in_ready, 1);
      check("out_valid_load", bus.out_valid, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = bytes[71 - 8*i -: 8];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // mode 0: out_ready high; 1: pattern 1,0,0,1; 2: random
  task automatic stream(input int mode, input int max_xfers, output int cycles);
    int   xf;
    logic rdy;
    xf = 0;
    cycles = 0;
    while (sb.size() > 0 && xf < max_xfers && cycles < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cycles % 4) == 0) || ((cycles % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      check("out_valid", bus.out_valid, 1);
      check("in_ready_stream", bus.in_ready, 0);
      check("out_x", bus.out_x, sb[0].x);
      check("out_y", bus.out_y, sb[0].y);
      check("out_idx", bus.out_idx, sb[0].idx);
      check("out_last", bus.out_last, sb[0].last);
      check("epoch", epoch, sb[0].ep);
      if (rdy) begin
        void'(sb.pop_front());
        xf++;
      end
      @(negedge clk);
      cycles++;
    end
    bus.out_ready = 1'b0;
    if (cycles >= 200) check("stream_timeout", sb.size(), 0);
  endtask

  task automatic check_done_hold();
    check("done", done, 1);
    check("out_valid_done", bus.out_valid, 0);
    check("in_ready_done", bus.in_ready, 0);
    check("out_last_done", bus.out_last, 0);
    check("epoch_done", epoch, 4);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hAA;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("done_hold", done, 1);
      check("epoch_hold", epoch, 4);
      check("out_valid_hold", bus.out_valid, 0);
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    sb.delete();
    check("rs_in_ready", bus.in_ready, 1);
    check("rs_out_valid", bus.out_valid, 0);
    check("rs_epoch", epoch, 0);
    check("rs_idx", bus.out_idx, 0);
    check("rs_done", done, 0);
  endtask

  initial begin
    int cyc;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    vecs[0].bytes = {8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h01, 8'h01, 8'h02, 8'h01};
    vecs[0].xs    = {8'h32, 8'h54, 8'h21};
    vecs[0].ys    = 3'b011;
    vecs[0].mode  = 2'd0;
    vecs[1].bytes = {8'hF7, 8'hA5, 8'hFE, 8'h00, 8'h0F, 8'h03, 8'h8C, 8'h11, 8'h80};
    vecs[1].xs    = {8'h57, 8'hF0, 8'h1C};
    vecs[1].ys    = 3'b010;
    vecs[1].mode  = 2'd1;
    vecs[2].bytes = {8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h09, 8'h0A, 8'h01};
    vecs[2].xs    = {8'hFF, 8'h42, 8'hA9};
    vecs[2].ys    = 3'b101;
    vecs[2].mode  = 2'd2;

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_x", bus.out_x, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_epoch", epoch, 0);
    check("rst_done", done, 0);

    for (int v = 0; v < 3; v++) begin
      push_exp(vecs[v]);
      load(vecs[v].bytes, 9);
      check("load_latency_valid", bus.out_valid, 1);
      check("load_latency_idx", bus.out_idx, 0);
      stream(int'(vecs[v].mode), 12, cyc);
      if (vecs[v].mode == 2'd0) check("stream_cycles", cyc, 12);
      check_done_hold();
      do_restart();
    end

    // restart on the 5th streaming cycle, then a fresh load
    push_exp(vecs[0]);
    load(vecs[0].bytes, 9);
    stream(0, 4, cyc);
    check("pre_restart_idx", bus.out_idx, 1);
    check("pre_restart_epoch", epoch, 1);
    do_restart();
    push_exp(vecs[2]);
    load(vecs[2].bytes, 9);
    stream(0, 12, cyc);
    check_done_hold();
    do_restart();

    // reset after 4 bytes of a load, then a full load of different data
    load(vecs[0].bytes, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_x", bus.out_x, 0);
    check("mid_rst_epoch", epoch, 0);
    push_exp(vecs[1]);
    load(vecs[1].bytes, 9);
    stream(1, 12, cyc);
    check_done_hold();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
